// File: rtl/frame_bit_counter_pkg.sv
// Phase encoding shared by the TX control FSM, this counter and the serializer mux select.
package frame_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE   = 3'd0,
    PH_START  = 3'd1,
    PH_DATA   = 3'd2,
    PH_PARITY = 3'd3,
    PH_STOP   = 3'd4
  } phase_e;

endpackage

// File: rtl/frame_bit_counter_prescaler.sv
// bit_tick_prescaler: divides CLK into bit ticks while a frame is in flight.
// Used by frame_bit_counter only when FRAME_BIT_COUNTER_PRESCALE_EN is defined.
module bit_tick_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] div_r;
  logic [PRESCALE_W-1:0] cnt_r;
  logic                  wrap_s;

  assign wrap_s = (cnt_r == (div_r - PRESCALE_W'(1)));
  assign tick   = enable && wrap_s;

  // Divisor latch; a zero divisor behaves as divide-by-one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_r <= PRESCALE_W'(1);
    end else if (load) begin
      div_r <= (div == PRESCALE_W'(0)) ? PRESCALE_W'(1) : div;
    end else begin
      div_r <= div_r;
    end
  end

  // Cycle counter, wrapping on the same edge the tick is consumed.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      cnt_r <= PRESCALE_W'(0);
    end else if (enable) begin
      cnt_r <= wrap_s ? PRESCALE_W'(0) : (cnt_r + PRESCALE_W'(1));
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/frame_bit_counter.sv
// Serial TX frame bit-position counter: start, 1..DATA_WIDTH data bits, optional parity, 1/2 stop.
// Optional internal bit-tick prescaler enabled by FRAME_BIT_COUNTER_PRESCALE_EN.
module frame_bit_counter
  import frame_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int PRESCALE_W = 16,
  localparam int LEN_W      = $clog2(DATA_WIDTH + 1),
  localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic                  Bit_Tick,
  input  logic [LEN_W-1:0]      Data_Len,
  input  logic                  Parity_En,
  input  logic                  Two_Stop,
  input  logic                  Abort,
`ifdef FRAME_BIT_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] Prescale_Div,
`endif
  output logic [PHASE_W-1:0]    Phase,
  output logic [IDX_W-1:0]      Bit_Index,
  output logic                  Busy,
  output logic                  Last_Data_Bit,
  output logic                  Frame_Done
);

  phase_e             phase_r, phase_nxt_s;
  logic [IDX_W-1:0]   idx_r, idx_nxt_s;
  logic               stop_r, stop_nxt_s;
  logic [LEN_W-1:0]   len_r, len_nxt_s;
  logic               par_r, par_nxt_s;
  logic               two_r, two_nxt_s;
  logic               done_r, done_nxt_s;
  logic [LEN_W-1:0]   len_in_s;
  logic               accept_s;
  logic               last_data_s;
  logic               tick_s;

  assign accept_s    = Start && (phase_r == PH_IDLE) && !Abort;
  assign last_data_s = (phase_r == PH_DATA) && (LEN_W'(idx_r) == (len_r - LEN_W'(1)));

`ifdef FRAME_BIT_COUNTER_PRESCALE_EN
  logic unused_bit_tick_s;
  assign unused_bit_tick_s = Bit_Tick;

  bit_tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .CLK    (CLK),
    .RST    (RST),
    .load   (accept_s),
    .clear  (accept_s || Abort),
    .enable (phase_r != PH_IDLE),
    .div    (Prescale_Div),
    .tick   (tick_s)
  );
`else
  localparam int unused_prescale_w = PRESCALE_W;
  assign tick_s = Bit_Tick;
`endif

  // Out-of-range or zero lengths fall back to a full-width data field.
  always_comb begin
    len_in_s = Data_Len;
    if ((Data_Len == LEN_W'(0)) || (Data_Len > LEN_W'(DATA_WIDTH))) begin
      len_in_s = LEN_W'(DATA_WIDTH);
    end else begin
      len_in_s = Data_Len;
    end
  end

  // Next-state logic; Abort overrides Start and ticks.
  always_comb begin
    phase_nxt_s = phase_r;
    idx_nxt_s   = idx_r;
    stop_nxt_s  = stop_r;
    len_nxt_s   = len_r;
    par_nxt_s   = par_r;
    two_nxt_s   = two_r;
    done_nxt_s  = 1'b0;
    if (Abort) begin
      phase_nxt_s = PH_IDLE;
      idx_nxt_s   = IDX_W'(0);
      stop_nxt_s  = 1'b0;
    end else begin
      case (phase_r)
        PH_IDLE: begin
          if (Start) begin
            phase_nxt_s = PH_START;
            idx_nxt_s   = IDX_W'(0);
            stop_nxt_s  = 1'b0;
            len_nxt_s   = len_in_s;
            par_nxt_s   = Parity_En;
            two_nxt_s   = Two_Stop;
          end else begin
            phase_nxt_s = PH_IDLE;
          end
        end
        PH_START: begin
          if (tick_s) begin
            phase_nxt_s = PH_DATA;
            idx_nxt_s   = IDX_W'(0);
          end else begin
            phase_nxt_s = PH_START;
          end
        end
        PH_DATA: begin
          if (tick_s && last_data_s) begin
            phase_nxt_s = par_r ? PH_PARITY : PH_STOP;
            idx_nxt_s   = IDX_W'(0);
          end else if (tick_s) begin
            idx_nxt_s   = idx_r + IDX_W'(1);
          end else begin
            idx_nxt_s   = idx_r;
          end
        end
        PH_PARITY: begin
          if (tick_s) begin
            phase_nxt_s = PH_STOP;
          end else begin
            phase_nxt_s = PH_PARITY;
          end
        end
        PH_STOP: begin
          if (tick_s && two_r && !stop_r) begin
            stop_nxt_s  = 1'b1;
          end else if (tick_s) begin
            phase_nxt_s = PH_IDLE;
            stop_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            phase_nxt_s = PH_STOP;
          end
        end
        default: begin
          phase_nxt_s = PH_IDLE;
          idx_nxt_s   = IDX_W'(0);
          stop_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // State, latched frame configuration and the completion pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_r <= PH_IDLE;
      idx_r   <= IDX_W'(0);
      stop_r  <= 1'b0;
      len_r   <= LEN_W'(0);
      par_r   <= 1'b0;
      two_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      phase_r <= phase_nxt_s;
      idx_r   <= idx_nxt_s;
      stop_r  <= stop_nxt_s;
      len_r   <= len_nxt_s;
      par_r   <= par_nxt_s;
      two_r   <= two_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign Phase         = phase_r;
  assign Bit_Index     = idx_r;
  assign Busy          = (phase_r != PH_IDLE);
  assign Last_Data_Bit = last_data_s;
  assign Frame_Done    = done_r;

endmodule

// File: tb/tb_frame_bit_counter.sv
// Self-checking bench for frame_bit_counter; reference model expands each frame into a slot list.
module tb_frame_bit_counter;

  localparam int DW    = 8;
  localparam int LEN_W = 4;
  localparam int IDX_W = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             Start = 1'b0;
  logic             Bit_Tick = 1'b0;
  logic [LEN_W-1:0] Data_Len = 4'd0;
  logic             Parity_En = 1'b0;
  logic             Two_Stop = 1'b0;
  logic             Abort = 1'b0;
`ifdef FRAME_BIT_COUNTER_PRESCALE_EN
  logic [15:0]      Prescale_Div = 16'd1;
`endif
  logic [2:0]       Phase;
  logic [IDX_W-1:0] Bit_Index;
  logic             Busy;
  logic             Last_Data_Bit;
  logic             Frame_Done;

  int checks = 0;
  int fails  = 0;

  frame_bit_counter #(.DATA_WIDTH(DW), .PRESCALE_W(16)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Start         (Start),
    .Bit_Tick      (Bit_Tick),
    .Data_Len      (Data_Len),
    .Parity_En     (Parity_En),
    .Two_Stop      (Two_Stop),
    .Abort         (Abort),
`ifdef FRAME_BIT_COUNTER_PRESCALE_EN
    .Prescale_Div  (Prescale_Div),
`endif
    .Phase         (Phase),
    .Bit_Index     (Bit_Index),
    .Busy          (Busy),
    .Last_Data_Bit (Last_Data_Bit),
    .Frame_Done    (Frame_Done)
  );

  always #5 CLK = ~CLK;

  // Reference model: a frame is a list of slots, one per bit period.
  typedef struct { int ph; int idx; bit last; } slot_t;
  slot_t seq[$];
  int    pos    = -1;
  bit    m_done = 1'b0;

  task automatic build_frame(input int l, input bit p, input bit t);
    int n;
    slot_t s;
    n = (l == 0 || l > DW) ? DW : l;
    seq.delete();
    s.ph = 1; s.idx = 0; s.last = 1'b0; seq.push_back(s);
    for (int k = 0; k < n; k++) begin
      s.ph = 2; s.idx = k; s.last = (k == n - 1); seq.push_back(s);
    end
    s.ph = 3; s.idx = 0; s.last = 1'b0;
    if (p) seq.push_back(s);
    s.ph = 4;
    seq.push_back(s);
    if (t) seq.push_back(s);
  endtask

  task automatic model_edge();
    bit nd;
    nd = 1'b0;
    if (RST) pos = -1;
    else if (Abort) pos = -1;
    else if (pos < 0) begin
      if (Start) begin
        build_frame(int'(Data_Len), Parity_En, Two_Stop);
        pos = 0;
      end
    end else if (Bit_Tick) begin
      pos++;
      if (pos >= seq.size()) begin
        pos = -1;
        nd  = 1'b1;
      end
    end
    m_done = nd;
  endtask

  function automatic logic [8:0] exp_vec();
    logic [2:0] ph;
    logic [2:0] ix;
    logic       lst;
    if (pos < 0) begin
      ph = 3'd0; ix = 3'd0; lst = 1'b0;
    end else begin
      ph = 3'(seq[pos].ph); ix = 3'(seq[pos].idx); lst = seq[pos].last;
    end
    return {ph, ix, (pos >= 0), lst, m_done};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {Phase, Bit_Index, Busy, Last_Data_Bit, Frame_Done};
  endfunction

  task automatic drive(input bit rst, input bit st, input bit tk, input bit ab,
                       input int l, input bit p, input bit t);
    RST = rst; Start = st; Bit_Tick = tk; Abort = ab;
    Data_Len = 4'(l); Parity_En = p; Two_Stop = t;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== 9'd0) begin
      fails++; $display("FAIL reset_outputs: got %b expected %b", obs_vec(), 9'd0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL idle_tick: got %b expected %b", obs_vec(), exp_vec());
    end
  endtask

  // Runs one frame with a tick every 'period' cycles and checks tick count to Frame_Done.
  task automatic run_frame(input string nm, input int l, input bit p, input bit t,
                           input int period, input int exp_ticks);
    int  ticks, dones, lasts, post;
    bit  tk, was_busy;
    ticks = 0; dones = 0; lasts = 0; post = -1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, l, p, t);
    checks++;
    if (Phase !== 3'd1) begin
      fails++; $display("FAIL %s_accept: phase %0d expected 1", nm, Phase);
    end
    for (int c = 0; c < 400 && post != 0; c++) begin
      tk = ((c % period) == period - 1);
      was_busy = (pos >= 0);
      drive(1'b0, 1'b0, tk, 1'b0, l, p, t);
      if (tk && was_busy) ticks++;
      if (Last_Data_Bit) lasts++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL %s_cycle%0d: got %b expected %b", nm, c, obs_vec(), exp_vec());
      end
      if (Frame_Done) begin
        dones++;
        checks++;
        if (ticks !== exp_ticks) begin
          fails++; $display("FAIL %s_ticks: got %0d expected %0d", nm, ticks, exp_ticks);
        end
        post = 6;
      end
      if (post > 0) post--;
    end
    checks++;
    if (dones !== 1) begin
      fails++; $display("FAIL %s_done_pulses: got %0d expected 1", nm, dones);
    end
    checks++;
    if (lasts !== period) begin
      fails++; $display("FAIL %s_last_cycles: got %0d expected %0d", nm, lasts, period);
    end
  endtask

  task automatic test_8n1();
    run_frame("8n1", 8, 1'b0, 1'b0, 4, 1 + 8 + 0 + 1);
  endtask

  task automatic test_5e2();
    run_frame("5e2", 5, 1'b1, 1'b1, 3, 1 + 5 + 1 + 2);
  endtask

  task automatic test_len_clamp();
    run_frame("len0", 0, 1'b0, 1'b0, 2, 1 + 8 + 1);
    run_frame("len12", 12, 1'b0, 1'b1, 2, 1 + 8 + 2);
  endtask

  task automatic test_abort();
    int guard;
    bit tk;
    guard = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8, 1'b1, 1'b0);
    while (!(pos >= 0 && seq[pos].ph == 2 && seq[pos].idx == 3) && guard < 100) begin
      tk = guard[0];
      drive(1'b0, 1'b0, tk, 1'b0, 8, 1'b1, 1'b0);
      guard++;
    end
    checks++;
    if (Bit_Index !== 3'd3 || Phase !== 3'd2) begin
      fails++; $display("FAIL abort_reach_idx3: phase %0d idx %0d expected 2/3", Phase, Bit_Index);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 6, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== 9'd0) begin
      fails++; $display("FAIL abort_idle: got %b expected %b", obs_vec(), 9'd0);
    end
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 6, 1'b0, 1'b0);
      checks++;
      if (Frame_Done !== 1'b0 || Busy !== 1'b0) begin
        fails++; $display("FAIL abort_quiet%0d: done %b busy %b expected 0 0", c, Frame_Done, Busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int  guard, ticks;
    bit  got;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8, 1'b0, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      drive(1'b0, (c == 3), 1'b1, 1'b0, (c == 3) ? 3 : 8, (c == 3), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL b2b_first%0d: got %b expected %b", c, obs_vec(), exp_vec());
      end
      got = Frame_Done;
    end
    checks++;
    if (!got) begin
      fails++; $display("FAIL b2b_first_done: got 0 expected 1");
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5, 1'b1, 1'b1);
    checks++;
    if (Phase !== 3'd1) begin
      fails++; $display("FAIL b2b_restart: phase %0d expected 1", Phase);
    end
    ticks = 0; guard = 0; got = 1'b0;
    while (!got && guard < 40) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0);
      ticks++; guard++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL b2b_second%0d: got %b expected %b", guard, obs_vec(), exp_vec());
      end
      got = Frame_Done;
    end
    checks++;
    if (ticks !== 9) begin
      fails++; $display("FAIL b2b_second_ticks: got %0d expected 9", ticks);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) drive(1'b0, 1'b0, 1'b1, 1'b0, 8, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8, 1'b1, 1'b1);
    checks++;
    if (obs_vec() !== 9'd0) begin
      fails++; $display("FAIL mid_reset: got %b expected %b", obs_vec(), 9'd0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL post_reset: got %b expected %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 63) == 0),
            int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL random%0d: got %b expected %b", c, obs_vec(), exp_vec());
      end
    end
  endtask

`ifdef FRAME_BIT_COUNTER_PRESCALE_EN
  task automatic test_prescale(input int div, input int exp_cycles);
    int cyc;
    bit got;
    Prescale_Div = 16'(div);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      drive(1'b0, 1'b0, 1'($urandom), 1'b0, 8, 1'b0, 1'b0);
      cyc++;
      got = Frame_Done;
    end
    checks++;
    if (!got || cyc !== exp_cycles) begin
      fails++; $display("FAIL prescale_div%0d: done after %0d cycles expected %0d", div, cyc, exp_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef FRAME_BIT_COUNTER_PRESCALE_EN
    test_prescale(3, 30);
    test_prescale(0, 10);
`else
    test_8n1();
    test_5e2();
    test_len_clamp();
    test_abort();
    test_back_to_back();
    test_mid_reset();
    test_random();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
